pc_seq_unit: RTL
================

Name: pc_seq_unit

Overview:
Parametrised program-counter sequencer for the pipelined MIPS-subset core; it replaces the single-width fixed PC register stage.
- Holds the fetch PC and evaluates six branch conditions from ALU flags.
- Arbitrates exception, branch, jump-register and jump redirects by fixed priority.
- Latches a redirect that arrives while fetch is stalled and applies it when the stall releases; drives a flush pulse to IF/ID.

Parameters:
PC_WIDTH, 32, width of PC and all address ports
RESET_VEC, 32'h00400020, PC value loaded on reset
EXC_VEC, 32'h80000180, exception handler address (used only with PC_EXC_EN)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold PC (hazard unit)
branch  in  1  conditional branch resolved this cycle
br_cond  in  3  000 EQ, 001 NE, 010 LTZ, 011 GEZ, 100 LEZ, 101 GTZ, 11x never-taken
zero  in  1  ALU result == 0
alu_msb  in  1  ALU result bit 31
overflow  in  1  ALU signed overflow
br_target  in  PC_WIDTH  branch target address
jump  in  1  direct jump (j/jal)
jump_target  in  PC_WIDTH  jump address
jreg  in  1  jump register (jr)
jreg_target  in  PC_WIDTH  register-sourced target
exc  in  1  exception request (present only with PC_EXC_EN)
pc  out  PC_WIDTH  current fetch PC
pc_plus4  out  PC_WIDTH  pc + 4
flush  out  1  redirect accepted this cycle (combinational)
pend_valid  out  1  captured redirect waiting for stall release
misalign  out  1  sticky: a jreg target had bits[1:0] != 0

Behaviour:
- Reset (async, rst_n=0): pc=RESET_VEC, pend_valid=0, pend_addr=0, misalign=0; flush=0 while in reset.
- Branch condition logic:
  - neg = alu_msb XOR overflow.
  - EQ=zero; NE=!zero; LTZ=neg; GEZ=!neg; LEZ=neg|zero; GTZ=!neg&!zero.
  - taken = branch & cond.
- Redirect request (req) priority: exc > taken > jreg > jump; target is the winning source address with bits[1:0] forced to 00.
- Not-taken branch is not a redirect.
- pc_plus4 = pc + 4, modulo 2^PC_WIDTH; 0xFFFFFFFC wraps to 0.
- State machine: IDLE (pend_valid=0) and PEND (pend_valid=1).
- IDLE, stall=0:
  - req: pc<=target, flush=1.
  - No req: pc<=pc_plus4.
- IDLE, stall=1:
  - pc holds.
  - req: pend_addr<=target, go to PEND, flush=1.
- PEND, stall=1:
  - pc holds.
  - New req of strictly higher priority than the captured source overwrites pend_addr (flush=1); equal or lower priority is ignored (flush=0).
  - Captured source priority is stored in a 2-bit register.
- PEND, stall=0:
  - pc<=pend_addr, return to IDLE.
  - Exception in the same cycle overrides: pc<=EXC_VEC, flush=1.
  - Other simultaneous requests are dropped.
- misalign sets on any accepted jreg whose jreg_target[1:0]!=0; cleared only by reset.
- Reset mid-PEND discards the pending redirect.
- Latency: accepted redirect is visible on pc one cycle later (next edge), or on the first edge after stall falls.

Optional Feature:
PC_EXC_EN
- Defined: exc port exists; highest priority; target EXC_VEC; overrides stall and pending (pc<=EXC_VEC on the next edge even if stall=1, pend cleared).
- Undefined: exc port and EXC_VEC logic absent; priority is taken > jreg > jump.

Test Plan:
- Reset release: rst_n low then high -> pc=0x00400020, then 0x00400024, 0x00400028 on successive edges.
- Branch compare:
  - branch=1, br_cond=010, alu_msb=0, overflow=1, br_target=0x00400100 -> taken (neg=1), flush=1, pc=0x00400100 next cycle.
  - Same inputs with br_cond=011 -> not taken, pc advances by 4.
- Stall capture: stall=1, jump=1, jump_target=0x00400200 -> pend_valid=1, pc holds.
  - Then branch taken to 0x00400300 while stalled -> pend_addr replaced.
  - Stall drops -> pc=0x00400300, pend_valid=0.
- Priority: jump, jreg (0x00400404) and taken branch (0x00400500) asserted together with stall=0 -> pc=0x00400500.
  - jreg_target=0x00400406 alone -> pc=0x00400404, misalign=1 sticky.
- Wrap: force pc=0xFFFFFFFC via jump -> pc_plus4=0, next pc=0.
- PC_EXC_EN: exc=1 during stall with pending redirect -> pc=0x80000180 next edge, pend_valid=0, flush=1.
  - Undefined build: exc port absent; jump during stall is captured normally.

Source files
------------

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: branch evaluation, prioritised redirects, stall-time capture.
// Optional exception redirect is compiled in with `define PC_EXC_EN.
module pc_seq_unit #(
    parameter int unsigned           PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_VEC = PC_WIDTH'(32'h0040_0020),
    parameter logic [PC_WIDTH-1:0]   EXC_VEC   = PC_WIDTH'(32'h8000_0180)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                branch,
    input  logic [2:0]          br_cond,
    input  logic                zero,
    input  logic                alu_msb,
    input  logic                overflow,
    input  logic [PC_WIDTH-1:0] br_target,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                jreg,
    input  logic [PC_WIDTH-1:0] jreg_target,
`ifdef PC_EXC_EN
    input  logic                exc,
`endif
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic                flush,
    output logic                pend_valid,
    output logic                misalign
);

    localparam logic [1:0] PRI_JUMP = 2'd0;
    localparam logic [1:0] PRI_JREG = 2'd1;
    localparam logic [1:0] PRI_BR   = 2'd2;
    localparam logic [1:0] PRI_EXC  = 2'd3;

    typedef enum logic {S_IDLE = 1'b0, S_PEND = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [PC_WIDTH-1:0]   pc_plus4_q;
    logic [PC_WIDTH-1:0]   pend_addr_q, pend_addr_d;
    logic [1:0]            pend_pri_q, pend_pri_d;
    logic                  misalign_q, misalign_d;

    logic                  exc_fire;
    logic                  neg;
    logic                  cond;
    logic                  taken;
    logic                  req;
    logic [1:0]            req_pri;
    logic [PC_WIDTH-1:0]   req_src;
    logic [PC_WIDTH-1:0]   req_tgt;
    logic                  flush_raw;

`ifdef PC_EXC_EN
    assign exc_fire = exc;
`else
    assign exc_fire = 1'b0;
`endif

    assign neg = alu_msb ^ overflow;

    // Branch condition decode and fixed-priority redirect selection
    always_comb begin
        cond    = 1'b0;
        req     = 1'b1;
        req_pri = PRI_JUMP;
        req_src = jump_target;
        case (br_cond)
            3'b000:  cond = zero;
            3'b001:  cond = ~zero;
            3'b010:  cond = neg;
            3'b011:  cond = ~neg;
            3'b100:  cond = neg | zero;
            3'b101:  cond = ~neg & ~zero;
            default: cond = 1'b0;
        endcase
        taken = branch & cond;
        if (exc_fire) begin
            req_pri = PRI_EXC;
            req_src = EXC_VEC;
        end else if (taken) begin
            req_pri = PRI_BR;
            req_src = br_target;
        end else if (jreg) begin
            req_pri = PRI_JREG;
            req_src = jreg_target;
        end else if (!jump) begin
            req = 1'b0;
        end
    end

    assign req_tgt = req_src & ~PC_WIDTH'(3);

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_VEC;
            pc_plus4_q  <= RESET_VEC + PC_WIDTH'(4);
            pend_addr_q <= '0;
            pend_pri_q  <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_plus4_q  <= pc_d + PC_WIDTH'(4);
            pend_addr_q <= pend_addr_d;
            pend_pri_q  <= pend_pri_d;
            misalign_q  <= misalign_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (stall && req && !exc_fire) state_d = S_PEND;
            S_PEND: if (!stall || exc_fire)        state_d = S_IDLE;
            default:                               state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        pc_d        = pc_q;
        pend_addr_d = pend_addr_q;
        pend_pri_d  = pend_pri_q;
        flush_raw   = 1'b0;
        if (exc_fire) begin
            pc_d        = EXC_VEC;
            pend_addr_d = '0;
            pend_pri_d  = '0;
            flush_raw   = 1'b1;
        end else if (state_q == S_IDLE) begin
            if (!stall) begin
                pc_d      = req ? req_tgt : pc_plus4_q;
                flush_raw = req;
            end else if (req) begin
                pend_addr_d = req_tgt;
                pend_pri_d  = req_pri;
                flush_raw   = 1'b1;
            end
        end else begin
            if (!stall) begin
                pc_d = pend_addr_q;
            end else if (req && (req_pri > pend_pri_q)) begin
                pend_addr_d = req_tgt;
                pend_pri_d  = req_pri;
                flush_raw   = 1'b1;
            end
        end
        misalign_d = misalign_q |
                     (flush_raw && !exc_fire && (req_pri == PRI_JREG) && (jreg_target[1:0] != 2'b00));
    end

    assign pc         = pc_q;
    assign pc_plus4   = pc_plus4_q;
    assign flush      = flush_raw & rst_n;
    assign pend_valid = (state_q == S_PEND);
    assign misalign   = misalign_q;

endmodule
